// File: rtl/subtractor_serial_n.sv
// subtractor_serial_n
// Digit-serial subtractor: diff_o = a_i - b_i - borrow_i (mod 2^NB_BIT),
// DIGIT bits per cycle, LSB digit first. The inter-digit borrow lives in a
// register, so the carry chain is only DIGIT+1 bits long.
//
// Optional feature (macro MOD_SUB_EN): adds port q_i and a CORR state.
// When the raw subtraction borrows, q is added back digit-serially, which
// gives (a-b) mod q for a,b < q. In this build borrow_i is ignored.
//
// Ports:
//   clk_i     rising-edge clock
//   rst_ni    asynchronous active-low reset
//   valid_i   operands valid             ready_o   operands can be accepted
//   a_i       minuend                    b_i       subtrahend
//   borrow_i  incoming borrow (chaining)
//   q_i       modulus, sampled at accept (MOD_SUB_EN only)
//   valid_o   result valid, held until ready_i
//   ready_i   downstream takes the result
//   diff_o    result                     borrow_o  borrow out of the MSB digit
//                                                  (raw, before correction)
module subtractor_serial_n #(
    parameter int NB_BIT = 32,
    parameter int DIGIT  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [NB_BIT-1:0] a_i,
    input  logic [NB_BIT-1:0] b_i,
    input  logic              borrow_i,
`ifdef MOD_SUB_EN
    input  logic [NB_BIT-1:0] q_i,
`endif
    output logic              valid_o,
    input  logic              ready_i,
    output logic [NB_BIT-1:0] diff_o,
    output logic              borrow_o
);
    localparam int NB_DIG = NB_BIT / DIGIT;
    localparam int CNT_W  = (NB_DIG > 1) ? $clog2(NB_DIG) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB_DIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
`ifdef MOD_SUB_EN
        CORR = 2'd3,
`endif
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [NB_BIT-1:0] a_reg, a_next;
    logic [NB_BIT-1:0] b_reg, b_next;
    logic [NB_BIT-1:0] res_reg, res_next;
    logic              borrow_reg, borrow_next;
    logic [NB_BIT-1:0] diff_reg, diff_next;
    logic              borrow_out_reg, borrow_out_next;
    logic              accept;

    // One digit of the subtraction, DIGIT+1 bits so the top bit is the borrow.
    logic [DIGIT:0]    dig_d;
    logic [NB_BIT-1:0] res_sub;
    assign dig_d   = {1'b0, a_reg[DIGIT-1:0]} - {1'b0, b_reg[DIGIT-1:0]}
                   - (DIGIT+1)'(borrow_reg);
    // New digit enters at the MSB side; after NB_DIG shifts the word is aligned.
    assign res_sub = (res_reg >> DIGIT) | (NB_BIT'(dig_d[DIGIT-1:0]) << (NB_BIT - DIGIT));

`ifdef MOD_SUB_EN
    logic [NB_BIT-1:0] q_reg, q_next;
    logic              carry_reg, carry_next;
    logic [DIGIT:0]    dig_s;
    logic [NB_BIT-1:0] res_corr;
    logic              unused_borrow_i;
    assign unused_borrow_i = borrow_i;
    // Correction re-circulates the raw difference through the same shift
    // register, adding q one digit at a time; the final carry is dropped.
    assign dig_s    = {1'b0, res_reg[DIGIT-1:0]} + {1'b0, q_reg[DIGIT-1:0]}
                    + (DIGIT+1)'(carry_reg);
    assign res_corr = (res_reg >> DIGIT) | (NB_BIT'(dig_s[DIGIT-1:0]) << (NB_BIT - DIGIT));
`endif

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        a_next          = a_reg;
        b_next          = b_reg;
        res_next        = res_reg;
        borrow_next     = borrow_reg;
        diff_next       = diff_reg;
        borrow_out_next = borrow_out_reg;
`ifdef MOD_SUB_EN
        q_next          = q_reg;
        carry_next      = carry_reg;
`endif
        ready_o         = 1'b0;
        valid_o         = 1'b0;
        accept          = 1'b0;

        case (state_reg)
            IDLE: begin
                ready_o = 1'b1;
                accept  = valid_i;
            end
            SUB: begin
                a_next      = a_reg >> DIGIT;
                b_next      = b_reg >> DIGIT;
                res_next    = res_sub;
                borrow_next = dig_d[DIGIT];
                cnt_next    = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
`ifdef MOD_SUB_EN
                    if (dig_d[DIGIT]) begin
                        state_next = CORR;
                        carry_next = 1'b0;
                    end else begin
                        state_next      = DONE;
                        diff_next       = res_sub;
                        borrow_out_next = 1'b0;
                    end
`else
                    state_next      = DONE;
                    diff_next       = res_sub;
                    borrow_out_next = dig_d[DIGIT];
`endif
                end
            end
`ifdef MOD_SUB_EN
            CORR: begin
                q_next     = q_reg >> DIGIT;
                res_next   = res_corr;
                carry_next = dig_s[DIGIT];
                cnt_next   = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_LAST) begin
                    cnt_next        = '0;
                    state_next      = DONE;
                    diff_next       = res_corr;
                    // Only reached when the raw subtraction borrowed.
                    borrow_out_next = borrow_reg;
                end
            end
`endif
            DONE: begin
                valid_o = 1'b1;
                // Taking the result frees the block in the same cycle.
                ready_o = ready_i;
                if (ready_i) begin
                    state_next = IDLE;
                    accept     = valid_i;
                end
            end
            default: state_next = IDLE;
        endcase

        if (accept) begin
            state_next = SUB;
            cnt_next   = '0;
            a_next     = a_i;
            b_next     = b_i;
`ifdef MOD_SUB_EN
            borrow_next = 1'b0;
            q_next      = q_i;
`else
            borrow_next = borrow_i;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            res_reg        <= '0;
            borrow_reg     <= 1'b0;
            diff_reg       <= '0;
            borrow_out_reg <= 1'b0;
`ifdef MOD_SUB_EN
            q_reg          <= '0;
            carry_reg      <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            a_reg          <= a_next;
            b_reg          <= b_next;
            res_reg        <= res_next;
            borrow_reg     <= borrow_next;
            diff_reg       <= diff_next;
            borrow_out_reg <= borrow_out_next;
`ifdef MOD_SUB_EN
            q_reg          <= q_next;
            carry_reg      <= carry_next;
`endif
        end
    end

    assign diff_o   = diff_reg;
    assign borrow_o = borrow_out_reg;

endmodule

// File: tb/tb_subtractor_serial_n.sv
// tb_subtractor_serial_n
// Four instances at NB_BIT=16 with DIGIT = 1, 4, 8, 16; sel picks the
// instance that receives handshakes and whose outputs are observed.
// Directed vector table, hand-written backpressure / reset sequences and
// random operations against an arithmetic reference model.
module tb_subtractor_serial_n;
    localparam int NB_BIT = 16;
    localparam int NINST  = 4;
`ifdef MOD_SUB_EN
    localparam logic [15:0] Q = 16'd3329;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        valid_in, ready_in, bin;
    logic [15:0] a_in, b_in;
    int          sel;

    logic        rdy_v [NINST];
    logic        vld_v [NINST];
    logic        bo_v  [NINST];
    logic [15:0] diff_v[NINST];
    logic        rdy_m, vld_m, bo_m;
    logic [15:0] diff_m;

    int checks   = 0;
    int failures = 0;

    for (genvar gi = 0; gi < NINST; gi++) begin : g_dut
        localparam int DG = (gi == 0) ? 1 : (gi == 1) ? 4 : (gi == 2) ? 8 : 16;
        subtractor_serial_n #(.NB_BIT(NB_BIT), .DIGIT(DG)) u_dut (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .valid_i (valid_in && (sel == gi)),
            .ready_o (rdy_v[gi]),
            .a_i     (a_in),
            .b_i     (b_in),
            .borrow_i(bin),
`ifdef MOD_SUB_EN
            .q_i     (Q),
`endif
            .valid_o (vld_v[gi]),
            .ready_i (ready_in && (sel == gi)),
            .diff_o  (diff_v[gi]),
            .borrow_o(bo_v[gi])
        );
    end

    always_comb begin
        rdy_m  = rdy_v[sel];
        vld_m  = vld_v[sel];
        bo_m   = bo_v[sel];
        diff_m = diff_v[sel];
    end

    function automatic int nb_dig(input int s);
        case (s)
            0:       return 16;
            1:       return 4;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: plain arithmetic on integers.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic bi,
                         output logic [15:0] d, output logic bo, output int lat);
        int t;
`ifdef MOD_SUB_EN
        t   = int'(a) - int'(b);
        bo  = (t < 0);
        d   = bo ? 16'(t + 3329) : 16'(t);
        lat = nb_dig(sel) * (bo ? 2 : 1);
`else
        t   = int'(a) - int'(b) - int'(bi);
        bo  = (t < 0);
        d   = 16'(t);
        lat = nb_dig(sel);
`endif
    endtask

    // Counts rising edges from the accept edge until valid_o is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!vld_m && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!vld_m) begin
            checks++;
            failures++;
            $display("FAIL timeout sel=%0d actual=no_valid required=valid", sel);
        end
    endtask

    task automatic start_wait(input logic [15:0] a, input logic [15:0] b, input logic bi,
                              output int lat);
        int w;
        @(negedge clk);
        a_in = a; b_in = b; bin = bi; valid_in = 1'b1;
        w = 0;
        #1;
        while (!rdy_m && w < 100) begin
            @(negedge clk); #1;
            w++;
        end
        if (!rdy_m) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout sel=%0d actual=not_ready required=ready", sel);
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        wait_result(lat);
    endtask

    task automatic release_result();
        @(negedge clk);
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;
    endtask

    typedef struct {
        int          sel;
        logic [15:0] a;
        logic [15:0] b;
        logic        bi;
        logic [15:0] d;
        logic        bo;
        int          lat;
    } vec_t;

    vec_t        tab[6];
    int          lat, elat;
    logic [15:0] ra, rb, ed;
    logic        rbi, ebo;

    initial begin
`ifdef MOD_SUB_EN
        tab[0] = '{1, 16'd5,    16'd10,   1'b0, 16'd3324, 1'b1, 8};
        tab[1] = '{1, 16'd10,   16'd5,    1'b0, 16'd5,    1'b0, 4};
        tab[2] = '{1, 16'd10,   16'd5,    1'b1, 16'd5,    1'b0, 4};
        tab[3] = '{3, 16'd0,    16'd1,    1'b0, 16'd3328, 1'b1, 2};
        tab[4] = '{0, 16'd3328, 16'd0,    1'b0, 16'd3328, 1'b0, 16};
        tab[5] = '{2, 16'd100,  16'd3328, 1'b0, 16'd101,  1'b1, 4};
`else
        tab[0] = '{1, 16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 4};
        tab[1] = '{1, 16'h0000, 16'h0001, 1'b1, 16'hFFFE, 1'b1, 4};
        tab[2] = '{1, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 4};
        tab[3] = '{3, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1};
        tab[4] = '{0, 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 16};
        tab[5] = '{2, 16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 2};
`endif
        rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
        a_in = '0; b_in = '0; bin = 1'b0; sel = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state of every instance.
        for (int s = 0; s < NINST; s++) begin
            sel = s; #1;
            chk("reset_ready", 32'(rdy_m), 32'd1);
            chk("reset_valid", 32'(vld_m), 32'd0);
            chk("reset_diff", 32'(diff_m), 32'd0);
            chk("reset_borrow", 32'(bo_m), 32'd0);
            $display("reset sel=%0d ready=%0d valid=%0d diff=%0h borrow=%0d",
                     s, rdy_m, vld_m, diff_m, bo_m);
        end

        // Directed vectors.
        for (int i = 0; i < 6; i++) begin
            sel = tab[i].sel;
            start_wait(tab[i].a, tab[i].b, tab[i].bi, lat);
            chk("vec_diff", 32'(diff_m), 32'(tab[i].d));
            chk("vec_borrow", 32'(bo_m), 32'(tab[i].bo));
            chk("vec_latency", 32'(lat), 32'(tab[i].lat));
            $display("vec %0d sel=%0d a=%0h b=%0h bi=%0d -> diff=%0h borrow=%0d lat=%0d",
                     i, sel, tab[i].a, tab[i].b, tab[i].bi, diff_m, bo_m, lat);
            release_result();
        end

        // Backpressure: result held for 5 cycles, then taken together with a new accept.
        sel = 1;
        start_wait(16'h0050, 16'h0010, 1'b0, lat);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(vld_m), 32'd1);
            chk("bp_diff", 32'(diff_m), 32'h0040);
            chk("bp_borrow", 32'(bo_m), 32'd0);
            chk("bp_ready", 32'(rdy_m), 32'd0);
        end
        @(negedge clk);
        ready_in = 1'b1; valid_in = 1'b1; a_in = 16'd7; b_in = 16'd3; bin = 1'b0;
        #1;
        chk("bp_ready_pass", 32'(rdy_m), 32'd1);
        @(posedge clk); #1;
        valid_in = 1'b0; ready_in = 1'b0;
        chk("bp_taken", 32'(vld_m), 32'd0);
        wait_result(lat);
        chk("bp_next_latency", 32'(lat), 32'd4);
        chk("bp_next_diff", 32'(diff_m), 32'h0004);
        $display("backpressure next op diff=%0h lat=%0d", diff_m, lat);
        release_result();

        // Reset in the middle of SUB.
        @(negedge clk);
        a_in = 16'h0FF0; b_in = 16'h0001; bin = 1'b0; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(vld_m), 32'd0);
        chk("midrst_diff", 32'(diff_m), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst_ready", 32'(rdy_m), 32'd1);
        chk("postrst_valid", 32'(vld_m), 32'd0);
        chk("postrst_borrow", 32'(bo_m), 32'd0);
        start_wait(16'h0100, 16'h0001, 1'b0, lat);
        chk("postrst_diff", 32'(diff_m), 32'h00FF);
        chk("postrst_latency", 32'(lat), 32'd4);
        $display("reset recovery diff=%0h lat=%0d", diff_m, lat);
        release_result();

        // Random operations against the reference model.
        for (int s = 0; s < NINST; s++) begin
            sel = s;
            for (int n = 0; n < 250; n++) begin
`ifdef MOD_SUB_EN
                ra = 16'($urandom_range(0, 3328));
                rb = 16'($urandom_range(0, 3328));
`else
                ra = 16'($urandom);
                rb = 16'($urandom);
`endif
                rbi = 1'($urandom_range(0, 1));
                model(ra, rb, rbi, ed, ebo, elat);
                start_wait(ra, rb, rbi, lat);
                chk("rnd_diff", 32'(diff_m), 32'(ed));
                chk("rnd_borrow", 32'(bo_m), 32'(ebo));
                chk("rnd_latency", 32'(lat), 32'(elat));
                $display("rnd sel=%0d a=%0h b=%0h bi=%0d -> diff=%0h borrow=%0d lat=%0d",
                         s, ra, rb, rbi, diff_m, bo_m, lat);
                release_result();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/subtractor_serial_n.md
Name: subtractor_serial_n

Overview:
Digit-serial, multi-cycle successor to the combinational ripple subtractor. Computes diff_o = a_i - b_i - borrow_i, DIGIT bits per cycle, and keeps the inter-digit borrow in a register. This keeps the carry chain short for wide post-quantum operands. Valid/ready handshakes on both sides let it sit between operand buffers and the PQ arithmetic datapath.

Parameters:
NB_BIT, 32, operand and result width; must be a multiple of DIGIT.
DIGIT, 8, bits processed per cycle; 1 <= DIGIT <= NB_BIT.
(derived) NB_DIG = NB_BIT/DIGIT, digit count; counter width = max(1, $clog2(NB_DIG)).

Ports:
clk_i  input  1  clock, rising edge.
rst_ni  input  1  asynchronous active-low reset.
valid_i  input  1  operands valid.
ready_o  output  1  block can accept operands.
a_i  input  NB_BIT  minuend.
b_i  input  NB_BIT  subtrahend.
borrow_i  input  1  incoming borrow, for chaining wider subtractions.
valid_o  output  1  result valid; held until accepted.
ready_i  input  1  downstream accepts result.
diff_o  output  NB_BIT  result, mod 2^NB_BIT.
borrow_o  output  1  final borrow out of the MSB digit.

Behaviour:
- Reset (async, rst_ni=0): state=IDLE; counter=0; operand/result shift registers=0; valid_o=0, diff_o=0, borrow_o=0, ready_o=1 on the first cycle after release.
- FSM states: IDLE, SUB, DONE (plus CORR under the optional feature).
- IDLE:
  - ready_o=1.
  - On valid_i&ready_o: latch a_i, b_i into shift registers; load the borrow register with borrow_i; clear the counter; go to SUB.
- SUB, one digit per cycle, LSB digit first:
  - d = a_dig - b_dig - borrow_reg, computed in DIGIT+1 bits.
  - The result digit enters the MSB side of the result shift register.
  - borrow_reg = d[DIGIT].
  - On counter == NB_DIG-1: go to DONE (or CORR).
- Latency: valid_o rises exactly NB_DIG cycles after the accept edge. For NB_DIG=1 it rises on the next cycle.
- DONE:
  - valid_o=1; diff_o and borrow_o stay stable until valid_o&ready_i.
  - ready_o = ready_i, so a new operand can be accepted in the same cycle the result is taken. That gives back-to-back throughput of one op per NB_DIG+1 cycles.
  - If a new operand is accepted that cycle, go to SUB; otherwise go to IDLE.
- valid_i while in SUB or CORR is ignored (ready_o=0). Operands need not stay stable after acceptance.
- diff_o and borrow_o are registered outputs that change only on entry to DONE or on reset. Between operations they hold the last result; valid_o qualifies them.
- Wrap-around: a < b+borrow_i gives the two's-complement result and borrow_o=1, e.g. 0 - 1 = all ones.
- Reset mid-operation: the operation is aborted with no output; all state returns to its reset values.

Optional Feature:
Macro MOD_SUB_EN.
- Defined:
  - Adds input port q_i [NB_BIT] (modulus, sampled at accept) and state CORR.
  - After SUB, if borrow_reg=1, CORR runs a further NB_DIG digit-serial cycles adding q (digit carry in a register, final carry discarded). diff_o is then (a-b) mod q for a,b < q.
  - If borrow_reg=0, go directly to DONE.
  - Latency is NB_DIG or 2*NB_DIG cycles.
  - borrow_o reports the raw borrow before correction.
  - borrow_i is ignored (treated as 0).
- Undefined: no q_i port, no CORR state, plain subtraction.

Test Plan:
1. NB_BIT=16, DIGIT=4; a=0x1234, b=0x0235, borrow_i=0 -> valid_o exactly 4 cycles after accept; diff_o=0x0FFF, borrow_o=0.
2. a=0x0000, b=0x0001, borrow_i=1 -> diff_o=0xFFFE, borrow_o=1. Then a=0xFFFF, b=0xFFFF, borrow_i=0 -> diff_o=0x0000, borrow_o=0.
3. Backpressure: hold ready_i=0 for 5 cycles in DONE -> valid_o, diff_o, borrow_o stable and ready_o=0. Raise ready_i together with valid_i (a=7, b=3) -> accepted that cycle; diff_o=0x0004 valid 4 cycles later.
4. Reset: assert rst_ni=0 at cycle 2 of SUB -> valid_o=0, diff_o=0, ready_o=1 after release. Next op a=0x0100, b=0x0001 -> diff_o=0x00FF.
5. DIGIT=16 (NB_DIG=1): a=0x8000, b=0x0001 -> valid_o one cycle after accept, diff_o=0x7FFF. Also random 1000-op comparison against a - b - borrow_i for DIGIT in {1,4,8,16}.
6. MOD_SUB_EN, q=3329, NB_BIT=16, DIGIT=4:
   - a=5, b=10 -> diff_o=3324, borrow_o=1, latency 8.
   - a=10, b=5 -> diff_o=5, latency 4.
